// File: rtl/fifo_rd_unpack_if.sv
// fifo_rd_unpack_if: FIFO read port plus narrow slice stream.
// master is the unpacker side, slave is the FIFO/sink side.
interface fifo_rd_unpack_if #(
    parameter int IN_W  = 32,
    parameter int OUT_W = 8
);
    logic             fifo_empty;
    logic [IN_W-1:0]  fifo_rd_data;
    logic             fifo_rd_en;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;
    logic             out_last;

    modport master (
        input  fifo_empty,
        input  fifo_rd_data,
        input  out_ready,
        output fifo_rd_en,
        output out_valid,
        output out_data,
        output out_last
    );

    modport slave (
        output fifo_empty,
        output fifo_rd_data,
        output out_ready,
        input  fifo_rd_en,
        input  out_valid,
        input  out_data,
        input  out_last
    );
endinterface

// File: rtl/fifo_rd_unpack.sv
// fifo_rd_unpack: pops wide FIFO words and emits them as narrow slices.
// Sustains one slice per cycle with no bubble between words.
module fifo_rd_unpack #(
    parameter int IN_W      = 32,
    parameter int OUT_W     = 8,
    parameter int LSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    output logic             busy,
    fifo_rd_unpack_if.master bus
);
    localparam int RATIO = IN_W / OUT_W;
    localparam int CNT_W = (RATIO > 1) ? $clog2(RATIO) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RATIO - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    localparam logic [0:0] EMPTY = 1'b0;
    localparam logic [0:0] SHIFT = 1'b1;

    if (IN_W % OUT_W != 0) begin : g_bad_ratio
        $error("fifo_rd_unpack: IN_W must be a multiple of OUT_W");
    end

    logic [IN_W-1:0]             hold_r;
    logic [0:0]                  hold_valid_r;
    logic [CNT_W-1:0]            cnt_r;
    logic [RATIO-1:0][OUT_W-1:0] slices;
    logic [CNT_W-1:0]            sel;
    logic                        accept;
    logic                        word_done;

    // Slice select and handshake decode, all from registered state.
    always_comb begin
        slices         = hold_r;
        sel            = (LSB_FIRST != 0) ? cnt_r : CNT_LAST - cnt_r;
        bus.out_valid  = (hold_valid_r == SHIFT);
        bus.out_last   = (hold_valid_r == SHIFT) && (cnt_r == CNT_LAST);
        bus.out_data   = (hold_valid_r == SHIFT) ? slices[sel] : '0;
        accept         = bus.out_valid & bus.out_ready;
        word_done      = accept & bus.out_last;
        // Refill on the last accepted slice so words run back to back.
        bus.fifo_rd_en = ~rst & ~flush & ~bus.fifo_empty
                       & ((hold_valid_r == EMPTY) | word_done);
        busy           = hold_valid_r[0];
    end

    // EMPTY/SHIFT state, held word and slice counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_r       <= '0;
            hold_valid_r <= EMPTY;
            cnt_r        <= '0;
        end else if (flush) begin
            hold_valid_r <= EMPTY;
            cnt_r        <= '0;
        end else if (bus.fifo_rd_en) begin
            hold_r       <= bus.fifo_rd_data;
            hold_valid_r <= SHIFT;
            cnt_r        <= '0;
        end else if (word_done) begin
            hold_valid_r <= EMPTY;
            cnt_r        <= '0;
        end else if (accept) begin
            cnt_r        <= cnt_r + CNT_ONE;
        end
    end
endmodule

// File: tb/tb_fifo_rd_unpack.sv
// tb_fifo_rd_unpack: FIFO model feeding two unpackers (LSB and MSB first).
// A per-cycle word/slice model is checked against both, plus literals.
module tb_fifo_rd_unpack;
    localparam int RATIO = 4;
    localparam int DEPTH = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        empty   [2];
    logic [31:0] rd_data [2];
    logic        rd_en   [2];
    logic        flush   [2];
    logic        ovalid  [2];
    logic        oready  [2];
    logic        olast   [2];
    logic        busy    [2];
    logic [7:0]  odata   [2];

    logic [31:0] mem [2][DEPTH];
    int          wp  [2];
    int          rp  [2];
    int          mrp [2];
    bit          pop_q [2];

    logic [31:0] cur  [2];
    int          rem  [2];
    logic [7:0]  gotd [2][DEPTH];
    logic        gotl [2][DEPTH];
    int          gn   [2];
    int          rdc  [2];
    int          vrun [2];
    int          vmax [2];

    int checks = 0;
    int errors = 0;

    fifo_rd_unpack_if #(.IN_W(32), .OUT_W(8)) bus0 ();
    fifo_rd_unpack_if #(.IN_W(32), .OUT_W(8)) bus1 ();

    assign bus0.fifo_empty   = empty[0];
    assign bus0.fifo_rd_data = rd_data[0];
    assign bus0.out_ready    = oready[0];
    assign rd_en[0]          = bus0.fifo_rd_en;
    assign ovalid[0]         = bus0.out_valid;
    assign odata[0]          = bus0.out_data;
    assign olast[0]          = bus0.out_last;

    assign bus1.fifo_empty   = empty[1];
    assign bus1.fifo_rd_data = rd_data[1];
    assign bus1.out_ready    = oready[1];
    assign rd_en[1]          = bus1.fifo_rd_en;
    assign ovalid[1]         = bus1.out_valid;
    assign odata[1]          = bus1.out_data;
    assign olast[1]          = bus1.out_last;

    for (genvar g = 0; g < 2; g++) begin : g_fifo
        assign empty[g]   = (rp[g] == wp[g]);
        assign rd_data[g] = mem[g][rp[g] % DEPTH];
    end

    fifo_rd_unpack #(.IN_W(32), .OUT_W(8), .LSB_FIRST(1)) dut0 (
        .clk   (clk),
        .rst   (rst),
        .flush (flush[0]),
        .busy  (busy[0]),
        .bus   (bus0.master)
    );

    fifo_rd_unpack #(.IN_W(32), .OUT_W(8), .LSB_FIRST(0)) dut1 (
        .clk   (clk),
        .rst   (rst),
        .flush (flush[1]),
        .busy  (busy[1]),
        .bus   (bus1.master)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // k-th slice in output order of word w.
    function automatic logic [7:0] slice_of(input logic [31:0] w,
                                            input int k, input bit lsb);
        int s;
        s = lsb ? k : RATIO - 1 - k;
        return 8'(w >> (8 * s));
    endfunction

    task automatic push(input int l, input logic [31:0] w);
        mem[l][wp[l] % DEPTH] = w;
        wp[l]++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Model: rem slices left of word cur; refill whenever it runs out.
    logic       ev, el, er;
    logic [7:0] ed;
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            ev = (rem[i] > 0);
            el = (rem[i] == 1);
            ed = ev ? slice_of(cur[i], RATIO - rem[i], i == 0) : 8'h00;
            er = !rst && !flush[i] && (mrp[i] != wp[i])
                 && (rem[i] == 0 || (rem[i] == 1 && oready[i]));
            chk($sformatf("l%0d_valid", i), 32'(ovalid[i]), 32'(ev));
            chk($sformatf("l%0d_last", i), 32'(olast[i]), 32'(el));
            chk($sformatf("l%0d_data", i), 32'(odata[i]), 32'(ed));
            chk($sformatf("l%0d_busy", i), 32'(busy[i]), 32'(ev));
            chk($sformatf("l%0d_rd_en", i), 32'(rd_en[i]), 32'(er));
            pop_q[i] = rd_en[i];
            if (rd_en[i]) rdc[i]++;
            if (ovalid[i]) vrun[i]++;
            else vrun[i] = 0;
            if (vrun[i] > vmax[i]) vmax[i] = vrun[i];
            if (!rst && ovalid[i] && oready[i]) begin
                gotd[i][gn[i] % DEPTH] = odata[i];
                gotl[i][gn[i] % DEPTH] = olast[i];
                gn[i]++;
            end
            if (rst || flush[i]) begin
                rem[i] = 0;
            end else begin
                if (rem[i] > 0 && oready[i]) rem[i]--;
                if (er) begin
                    cur[i] = mem[i][mrp[i] % DEPTH];
                    mrp[i]++;
                    rem[i] = RATIO;
                end
            end
        end
    end

    // FIFO side: pop the head after each edge where rd_en was high.
    always @(posedge clk) begin
        #1;
        for (int i = 0; i < 2; i++)
            if (pop_q[i]) rp[i]++;
    end

    initial begin
        logic [7:0] e1 [4];
        logic [7:0] e5 [6];
        logic [7:0] e6 [4];
        int r;
        for (int i = 0; i < 2; i++) begin
            wp[i] = 0; rp[i] = 0; mrp[i] = 0; pop_q[i] = 0;
            cur[i] = 0; rem[i] = 0; gn[i] = 0; rdc[i] = 0;
            vrun[i] = 0; vmax[i] = 0;
            flush[i] = 1'b0; oready[i] = 1'b1;
        end
        rst = 1'b1;
        repeat (3) step();
        chk("rst_valid", 32'(ovalid[0]), 32'h0);
        chk("rst_data", 32'(odata[0]), 32'h0);
        chk("rst_last", 32'(olast[0]), 32'h0);
        chk("rst_busy", 32'(busy[0]), 32'h0);
        chk("rst_rd_en", 32'(rd_en[0]), 32'h0);
        rst = 1'b0;
        step();

        // single word, LSB first
        gn[0] = 0; rdc[0] = 0;
        push(0, 32'hA1B2C3D4);
        repeat (8) step();
        e1 = '{8'hD4, 8'hC3, 8'hB2, 8'hA1};
        chk("t1_count", 32'(gn[0]), 32'd4);
        for (int j = 0; j < 4; j++)
            chk($sformatf("t1_slice%0d", j), 32'(gotd[0][j]), 32'(e1[j]));
        chk("t1_last", 32'({gotl[0][3], gotl[0][2], gotl[0][1], gotl[0][0]}),
            32'b1000);
        chk("t1_pops", 32'(rdc[0]), 32'd1);
        chk("t1_busy", 32'(busy[0]), 32'h0);

        // three words back to back
        gn[0] = 0; rdc[0] = 0; vmax[0] = 0;
        push(0, 32'h03020100);
        push(0, 32'h07060504);
        push(0, 32'h0B0A0908);
        repeat (16) step();
        chk("t2_count", 32'(gn[0]), 32'd12);
        for (int j = 0; j < 12; j++)
            chk($sformatf("t2_slice%0d", j), 32'(gotd[0][j]), 32'(j));
        chk("t2_run", 32'(vmax[0]), 32'd12);
        chk("t2_pops", 32'(rdc[0]), 32'd3);

        // ready toggling 1,0,0,1
        gn[0] = 0;
        push(0, 32'h11223344);
        for (int c = 0; c < 16; c++) begin
            oready[0] = (c % 4 == 0) || (c % 4 == 3);
            step();
        end
        oready[0] = 1'b1;
        step();
        e1 = '{8'h44, 8'h33, 8'h22, 8'h11};
        chk("t3_count", 32'(gn[0]), 32'd4);
        for (int j = 0; j < 4; j++)
            chk($sformatf("t3_slice%0d", j), 32'(gotd[0][j]), 32'(e1[j]));

        // MSB first lane
        gn[1] = 0;
        push(1, 32'hDEADBEEF);
        repeat (8) step();
        e1 = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        chk("t4_count", 32'(gn[1]), 32'd4);
        for (int j = 0; j < 4; j++)
            chk($sformatf("t4_slice%0d", j), 32'(gotd[1][j]), 32'(e1[j]));
        chk("t4_last", 32'({gotl[1][3], gotl[1][2], gotl[1][1], gotl[1][0]}),
            32'b1000);

        // flush mid-word with the next word queued
        gn[0] = 0;
        push(0, 32'h01020304);
        push(0, 32'h55667788);
        repeat (3) step();
        oready[0] = 1'b0;
        flush[0]  = 1'b1;
        step();
        flush[0]  = 1'b0;
        oready[0] = 1'b1;
        chk("t5_post_valid", 32'(ovalid[0]), 32'h0);
        repeat (10) step();
        e5 = '{8'h04, 8'h03, 8'h88, 8'h77, 8'h66, 8'h55};
        chk("t5_count", 32'(gn[0]), 32'd6);
        for (int j = 0; j < 6; j++)
            chk($sformatf("t5_slice%0d", j), 32'(gotd[0][j]), 32'(e5[j]));

        // reset mid-word, FIFO holding another word
        push(0, 32'hCAFEF00D);
        push(0, 32'h12345678);
        repeat (2) step();
        chk("t6_busy", 32'(busy[0]), 32'h1);
        r = rp[0];
        rst = 1'b1;
        repeat (2) step();
        chk("t6_rp", 32'(rp[0]), 32'(r));
        chk("t6_valid", 32'(ovalid[0]), 32'h0);
        chk("t6_data", 32'(odata[0]), 32'h0);
        rst = 1'b0;
        gn[0] = 0;
        repeat (10) step();
        e6 = '{8'h78, 8'h56, 8'h34, 8'h12};
        chk("t6_count", 32'(gn[0]), 32'd4);
        for (int j = 0; j < 4; j++)
            chk($sformatf("t6_slice%0d", j), 32'(gotd[0][j]), 32'(e6[j]));
        chk("t6_fifo_empty", 32'(empty[0]), 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
